// File: rtl/data_mem_responder.sv
// Clocked data-memory slave for the thumb_pipe data port: strobe-driven reads and writes
// on a shared tri-state bus, with cycle-counted wait states instead of behavioural delays.
module data_mem_responder #(
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_BITS   = 8,
    parameter int READ_LAT    = 2,
    parameter int WRITE_LAT   = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 read_data_n,
    input  logic                 write_data_n,
    input  logic [WORD_SIZE-1:0] data_address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 proto_err
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] RD_LOAD   = 4'(READ_LAT - 1);
    localparam logic [3:0] WR_LOAD   = 4'(WRITE_LAT - 1);
    localparam logic [3:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        RD_HOLD,
        WR_CAPT,
        WR_COMMIT
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [3:0]             r_waitCnt;
    logic [3:0]             w_nextCnt;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [WORD_SIZE-1:0]   r_wdata;
    logic [WORD_SIZE-1:0]   r_rdata;
    logic                   r_protoErr;
    logic [WORD_SIZE-1:0]   r_mem [0:DEPTH-1];

    logic [ADDR_BITS-1:0]   w_index;
    logic                   w_latchAddr;
    logic                   w_latchData;
    logic                   w_loadRdata;
    logic                   w_memWe;
    logic                   w_protoSet;
    logic                   w_oe;
    logic                   w_unusedAddr;

    assign w_index      = data_address[ADDR_BITS-1:0];
    assign w_unusedAddr = &{1'b0, data_address[WORD_SIZE-1:ADDR_BITS]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_waitCnt  <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_protoErr <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextCnt;
            if (w_latchAddr) r_addr  <= w_index;
            if (w_latchData) r_wdata <= data;
            if (w_loadRdata) r_rdata <= r_mem[r_addr];
            if (w_protoSet)  r_protoErr <= 1'b1;
        end
    end

    // Array has no reset so its contents survive reset_n; a reset in WR_COMMIT drops the write.
    always_ff @(posedge clk) begin
        if (w_memWe) r_mem[r_addr] <= r_wdata;
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_waitCnt;
        w_latchAddr = 1'b0;
        w_latchData = 1'b0;
        w_loadRdata = 1'b0;
        w_memWe     = 1'b0;
        w_protoSet  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!write_data_n) begin
                    w_nextState = WR_CAPT;
                    w_latchAddr = 1'b1;
                    w_latchData = 1'b1;
                    w_protoSet  = !read_data_n;
                end else if (!read_data_n) begin
                    w_nextState = RD_WAIT;
                    w_latchAddr = 1'b1;
                    w_nextCnt   = RD_LOAD;
                end
            end
            RD_WAIT: begin
                if (read_data_n) begin
                    w_nextState = IDLE;
                end else if (r_waitCnt == 4'd0) begin
                    w_loadRdata = 1'b1;
                    w_nextState = RD_DRIVE;
                end else begin
                    w_nextCnt = r_waitCnt - 4'd1;
                end
            end
            RD_DRIVE: begin
                // Only the decoded index counts as an address change, so aliases do not re-fetch.
                if (read_data_n) begin
                    if (HOLD_CYCLES == 0) begin
                        w_nextState = IDLE;
                    end else begin
                        w_nextState = RD_HOLD;
                        w_nextCnt   = HOLD_LOAD;
                    end
                end else if (w_index != r_addr) begin
                    w_nextState = RD_WAIT;
                    w_latchAddr = 1'b1;
                    w_nextCnt   = RD_LOAD;
                end
            end
            RD_HOLD: begin
                if (!read_data_n) begin
                    w_nextState = RD_WAIT;
                    w_latchAddr = 1'b1;
                    w_nextCnt   = RD_LOAD;
                end else if (r_waitCnt == 4'd0) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextCnt = r_waitCnt - 4'd1;
                end
            end
            WR_CAPT: begin
                if (!write_data_n) begin
                    w_latchAddr = 1'b1;
                    w_latchData = 1'b1;
                    w_protoSet  = !read_data_n;
                end else begin
                    w_nextState = WR_COMMIT;
                    w_nextCnt   = WR_LOAD;
                end
            end
            WR_COMMIT: begin
                w_protoSet = !write_data_n;
                if (r_waitCnt == 4'd0) begin
                    w_memWe     = 1'b1;
                    w_nextState = IDLE;
                end else begin
                    w_nextCnt = r_waitCnt - 4'd1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Never drive the bus while the CPU is asserting its write strobe.
    assign w_oe       = ((r_state == RD_DRIVE) || (r_state == RD_HOLD)) && write_data_n;
    assign data       = w_oe ? r_rdata : {WORD_SIZE{1'bz}};
    assign data_valid = (r_state == RD_DRIVE) && write_data_n;
    assign busy       = (r_state != IDLE);
    assign proto_err  = r_protoErr;

endmodule
